// File: rtl/multi_axis_integrator.sv
// multi_axis_integrator: calibrated multi-axis rate integrator with optional IR heading fusion on axis 0
module multi_axis_integrator #(
  parameter int NUM_AXES  = 3,
  parameter int RATE_W    = 16,
  parameter int CAL_LOG2  = 11,
  parameter int ACC_W     = 27,
  parameter int HEAD_W    = 12,
  parameter int FUS_W     = 9,
  parameter int FUS_SHIFT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       strt_cal,
  input  logic                       vld,
  input  logic [NUM_AXES*RATE_W-1:0] rate,
  input  logic                       moving,
  input  logic                       en_fusion,
  input  logic [FUS_W-1:0]           IR_Dtrm,
  output logic                       calibrating,
  output logic                       cal_done,
  output logic                       rdy,
  output logic [NUM_AXES*HEAD_W-1:0] heading
);
  typedef enum logic [1:0] {IDLE, CAL, RUN} state_t;
  localparam logic [CAL_LOG2:0] CAL_N = {1'b1, {CAL_LOG2{1'b0}}};
  state_t state_q, state_d;
  logic s1_vld_q, s1_vld_d, cal_done_q, cal_done_d, rdy_q, rdy_d, cal_full;
  logic [CAL_LOG2:0] cnt_q, cnt_d;
  logic signed [RATE_W:0] comp_q [NUM_AXES];
  logic signed [RATE_W:0] comp_d [NUM_AXES];
  logic signed [ACC_W-1:0] acc_q [NUM_AXES];
  logic signed [ACC_W-1:0] acc_d [NUM_AXES];
  logic signed [RATE_W-1:0] off_q [NUM_AXES];
  logic signed [RATE_W-1:0] off_d [NUM_AXES];
  logic signed [RATE_W-1:0] rate_s [NUM_AXES];
  logic signed [FUS_W-1:0] ir_s;
  logic signed [ACC_W-1:0] fus_add;
  assign ir_s = IR_Dtrm;
  for (genvar g = 0; g < NUM_AXES; g++) begin : g_ax
    assign rate_s[g] = rate[g*RATE_W +: RATE_W];
    assign heading[g*HEAD_W +: HEAD_W] = acc_q[g][ACC_W-1 -: HEAD_W];
  end
  assign calibrating = state_q == CAL;
  assign cal_done = cal_done_q;
  assign rdy = rdy_q;
  always_comb begin
    state_d = state_q;
    s1_vld_d = 1'b0;
    cnt_d = cnt_q;
    acc_d = acc_q;
    off_d = off_q;
    cal_done_d = 1'b0;
    rdy_d = 1'b0;
    cal_full = state_q == CAL && cnt_q == CAL_N;
    fus_add = (state_q == RUN && en_fusion) ? -(ACC_W'(ir_s) <<< FUS_SHIFT) : '0;
    for (int i = 0; i < NUM_AXES; i++)
      comp_d[i] = state_q == RUN ? (RATE_W+1)'(rate_s[i]) - (RATE_W+1)'(off_q[i]) : (RATE_W+1)'(rate_s[i]);
    // restart beats everything, including an in-flight sample and the offset latch
    if (strt_cal) begin
      state_d = CAL;
      cnt_d = '0;
      acc_d = '{default: '0};
    end else if (cal_full) begin
      state_d = RUN;
      cal_done_d = 1'b1;
      for (int i = 0; i < NUM_AXES; i++) begin
        off_d[i] = RATE_W'(acc_q[i] >>> CAL_LOG2);
        acc_d[i] = '0;
      end
    end else begin
      s1_vld_d = vld && state_q != IDLE;
      if (s1_vld_q) begin
        rdy_d = state_q == RUN;
        cnt_d = state_q == CAL ? cnt_q + 1'b1 : cnt_q;
        if (state_q == CAL || moving) begin
          for (int i = 0; i < NUM_AXES; i++)
            acc_d[i] = acc_q[i] + ACC_W'(comp_q[i]);
          acc_d[0] = acc_d[0] + fus_add;
        end
      end
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      s1_vld_q <= 1'b0;
      cnt_q <= '0;
      cal_done_q <= 1'b0;
      rdy_q <= 1'b0;
      comp_q <= '{default: '0};
      acc_q <= '{default: '0};
      off_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      s1_vld_q <= s1_vld_d;
      cnt_q <= cnt_d;
      cal_done_q <= cal_done_d;
      rdy_q <= rdy_d;
      comp_q <= comp_d;
      acc_q <= acc_d;
      off_q <= off_d;
    end
endmodule
